peripheral_ahb_memtest_master: RTL and testbench
================================================

# peripheral_ahb_memtest_master

AHB-Lite master that fills a memory window with a generated pattern, reads it back, and counts mismatches. It sits directly upstream of the AHB-Lite single-port RAM slave, driving its H* inputs. It is used for RAM bring-up, BIST-style checks and pre-loading. Fully pipelined: with a zero-wait slave it issues one beat per cycle.

## Interface
- PLEN, 8, address width (byte addresses)
- XLEN, 32, data width; must be 32 or 64
- CNT_W, 8, width of `count` (beats per pass)
- HRESETn  in  1  async active-low reset
- HCLK  in  1  clock; all logic is on the rising edge
- start  in  1  single-cycle request pulse; accepted only in IDLE
- base  in  PLEN  start byte address; low log2(XLEN/8) bits ignored, treated as 0
- count  in  CNT_W  number of words per pass
- seed  in  XLEN  pattern seed
- busy  out  1  high from the cycle after an accepted `start` until `done`
- done  out  1  one-cycle pulse at end of test
- bus_err  out  1  sticky until next `start`; set if a slave ERROR response aborted the test
- err_cnt  out  16  mismatch count, saturating at 16'hFFFF
- first_err_addr  out  PLEN  address of the first mismatch; valid when err_cnt != 0
- HSEL  out  1;  HADDR  out  PLEN;  HWDATA  out  XLEN;  HWRITE  out  1
- HSIZE  out  3  constant: 3'b010 for XLEN=32, 3'b011 for XLEN=64
- HBURST  out  3  constant 3'b001 (INCR)
- HPROT  out  4  constant 4'b0011
- HTRANS  out  2;  HMASTLOCK  out  1 (constant 0)
- HRDATA  in  XLEN;  HREADY  in  1 (slave HREADYOUT);  HRESP  in  1

## Operation
- States are IDLE, WR, WDRAIN, RD, RDRAIN, FIN.
- IDLE: HTRANS=IDLE(00), HSEL=0. On `start`:
  - If count==0, go to FIN.
  - Otherwise latch base, count and seed, clear err_cnt, bus_err and first_err_addr, and go to WR.
- WR/RD address phase:
  - HSEL=1, HWRITE=1 in WR and 0 in RD.
  - Beat 0 is NONSEQ(10); later beats are SEQ(11).
  - HADDR = base + i*(XLEN/8), mod 2^PLEN (wraps silently).
  - The address phase and beat index advance only when HREADY=1.
  - After the last address phase completes, go to WDRAIN or RDRAIN.
- Write data: for beat i, HWDATA = pattern(i), driven in the cycle after beat i's address phase completes. HWDATA is held while HREADY=0.
- Pattern: pattern(i) = seed + i, mod 2^XLEN.
- WDRAIN: HTRANS=IDLE until the last write data phase completes (HREADY=1), then go to RD with the beat index reset to 0.
- Read data: when a read data phase completes (HREADY=1), compare HRDATA with pattern(j). On mismatch:
  - Increment err_cnt, saturating.
  - If this is the first mismatch, capture that beat's address in first_err_addr.
- RDRAIN: HTRANS=IDLE until the last read data completes and is compared, then go to FIN.
- FIN: done=1 for one cycle, busy=0, then return to IDLE. Results hold until the next accepted `start`.
- Slave error (HRESP=1 while HREADY=0, first cycle of the two-cycle ERROR response):
  - Drive HTRANS=IDLE from the next cycle.
  - Set bus_err and go to FIN.
  - Read data of the errored beat is not compared.
- `start` while busy is ignored.

## Timing
- Reset values (asynchronous): state=IDLE; busy=0, done=0, bus_err=0, err_cnt=0, first_err_addr=0, HSEL=0, HADDR=0, HWDATA=0, HWRITE=0, HTRANS=00. Constant outputs take their fixed values.
- Reset mid-test abandons the transfer immediately; no drain is performed.
- With a zero-wait slave, `start` sampled at edge 0 and count=N:
  - Write NONSEQ in cycle 1; write address phases in cycles 1..N.
  - WDRAIN in cycle N+1.
  - Read address phases in cycles N+2..2N+1.
  - RDRAIN in cycle 2N+2.
  - done in cycle 2N+3.
- Each HREADY=0 cycle stretches the sequence by exactly one cycle.
- count==0: done in cycle 1, no bus activity, err_cnt=0.

## Configuration
- PERIPHERAL_MEMTEST_ADDR_PATTERN_EN defined: pattern(i) = seed XOR the zero-extended byte address of beat i. This detects address aliasing.
- PERIPHERAL_MEMTEST_ADDR_PATTERN_EN undefined: pattern(i) = seed + i.
- Timing and interface are identical in both builds.

## Test plan
- Clean pass: zero-wait RAM model, base=0x10, count=4, seed=0xA5A5_0000. Writes go to 0x10/14/18/1C with data ...0000..0003. Expect done at cycle 11, err_cnt=0, bus_err=0.
- Wait states: RAM inserts 2 HREADY=0 cycles on every beat, count=3. Required: HADDR/HWDATA stable during waits; done at cycle 9+12=21.
- Mismatch: the RAM model corrupts bit 0 of word 0x18, base=0x10, count=4. Expect err_cnt=1 and first_err_addr=0x18. Repeat with 0x14 and 0x1C also corrupted: expect err_cnt=3, first_err_addr=0x14.
- Wrap and error: base=0xF8, count=4 (PLEN=8); addresses are 0xF8, 0xFC, 0x00, 0x04. Separately, ERROR returned on write beat 1: expect HTRANS=IDLE the next cycle, bus_err=1, done pulse, no read phase.
- Reset and control: HRESETn low during RD → all outputs return to reset values. `start` asserted while busy is ignored. count=0 → done at cycle 1 with no HSEL.

Source files
------------

// File: rtl/peripheral_ahb_memtest_master.sv
// rtl/peripheral_ahb_memtest_master.sv - AHB-Lite memory test master: pattern fill, read-back, mismatch count
// Define PERIPHERAL_MEMTEST_ADDR_PATTERN_EN to use seed XOR byte address as the pattern.
module peripheral_ahb_memtest_master #(
  parameter int PLEN  = 8,
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             HRESETn,
  input  logic             HCLK,
  input  logic             start,
  input  logic [PLEN-1:0]  base,
  input  logic [CNT_W-1:0] count,
  input  logic [XLEN-1:0]  seed,
  output logic             busy,
  output logic             done,
  output logic             bus_err,
  output logic [15:0]      err_cnt,
  output logic [PLEN-1:0]  first_err_addr,
  output logic             HSEL,
  output logic [PLEN-1:0]  HADDR,
  output logic [XLEN-1:0]  HWDATA,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [3:0]       HPROT,
  output logic [1:0]       HTRANS,
  output logic             HMASTLOCK,
  input  logic [XLEN-1:0]  HRDATA,
  input  logic             HREADY,
  input  logic             HRESP
);

  localparam int BYTES = XLEN / 8;
  localparam int ALIGN = $clog2(BYTES);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WDRAIN, S_RD, S_RDRAIN, S_FIN} state_t;

  state_t           state_q, state_d;
  logic [PLEN-1:0]  base_q, base_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  seed_q, seed_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] rd_idx_q, rd_idx_d;
  logic             rd_pend_q, rd_pend_d;
  logic [XLEN-1:0]  hwdata_q, hwdata_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic [PLEN-1:0]  first_err_q, first_err_d;
  logic             bus_err_q, bus_err_d;

  logic [PLEN-1:0]  wr_addr, rd_addr;
  logic [XLEN-1:0]  wr_pat, rd_pat;
  logic             last, active, slave_err;

  assign wr_addr = base_q + (PLEN'(idx_q) << ALIGN);
  assign rd_addr = base_q + (PLEN'(rd_idx_q) << ALIGN);
  assign last    = (idx_q == count_q - CNT_W'(1));
  assign active  = (state_q == S_WR) || (state_q == S_RD);
  // First cycle of the two-cycle ERROR response; abandon the test at once.
  assign slave_err = (state_q inside {S_WR, S_WDRAIN, S_RD, S_RDRAIN}) && !HREADY && HRESP;

`ifdef PERIPHERAL_MEMTEST_ADDR_PATTERN_EN
  assign wr_pat = seed_q ^ XLEN'(wr_addr);
  assign rd_pat = seed_q ^ XLEN'(rd_addr);
`else
  assign wr_pat = seed_q + XLEN'(idx_q);
  assign rd_pat = seed_q + XLEN'(rd_idx_q);
`endif

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    seed_d      = seed_q;
    idx_d       = idx_q;
    rd_idx_d    = rd_idx_q;
    rd_pend_d   = rd_pend_q;
    hwdata_d    = hwdata_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    bus_err_d   = bus_err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count == '0) begin
            state_d = S_FIN;
          end else begin
            base_d      = base & ~PLEN'(BYTES - 1);
            count_d     = count;
            seed_d      = seed;
            idx_d       = '0;
            rd_pend_d   = 1'b0;
            err_cnt_d   = '0;
            first_err_d = '0;
            bus_err_d   = 1'b0;
            state_d     = S_WR;
          end
        end
      end
      S_WR: begin
        if (HREADY) begin
          hwdata_d = wr_pat;
          idx_d    = idx_q + CNT_W'(1);
          if (last) state_d = S_WDRAIN;
        end
      end
      S_WDRAIN: begin
        if (HREADY) begin
          idx_d   = '0;
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (HREADY) begin
          rd_pend_d = 1'b1;
          rd_idx_d  = idx_q;
          idx_d     = idx_q + CNT_W'(1);
          if (last) state_d = S_RDRAIN;
        end
      end
      S_RDRAIN: begin
        if (HREADY) begin
          rd_pend_d = 1'b0;
          state_d   = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Read data phase completes in RD or RDRAIN while the next address phase may overlap.
    if ((state_q == S_RD || state_q == S_RDRAIN) && HREADY && rd_pend_q && (HRDATA != rd_pat)) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      if (err_cnt_q == 16'd0) first_err_d = rd_addr;
    end

    if (slave_err) begin
      bus_err_d = 1'b1;
      rd_pend_d = 1'b0;
      state_d   = S_FIN;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      count_q     <= '0;
      seed_q      <= '0;
      idx_q       <= '0;
      rd_idx_q    <= '0;
      rd_pend_q   <= 1'b0;
      hwdata_q    <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      seed_q      <= seed_d;
      idx_q       <= idx_d;
      rd_idx_q    <= rd_idx_d;
      rd_pend_q   <= rd_pend_d;
      hwdata_q    <= hwdata_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign busy           = state_q inside {S_WR, S_WDRAIN, S_RD, S_RDRAIN};
  assign done           = (state_q == S_FIN);
  assign bus_err        = bus_err_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_q;

  assign HSEL      = active;
  assign HADDR     = wr_addr;
  assign HWDATA    = hwdata_q;
  assign HWRITE    = (state_q == S_WR);
  assign HTRANS    = !active ? 2'b00 : ((idx_q == '0) ? 2'b10 : 2'b11);
  assign HSIZE     = (XLEN == 64) ? 3'b011 : 3'b010;
  assign HBURST    = 3'b001;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_peripheral_ahb_memtest_master.sv
// tb/tb_peripheral_ahb_memtest_master.sv - directed and randomized bench for the AHB memtest master
module tb_peripheral_ahb_memtest_master;

  localparam int PLEN  = 8;
  localparam int XLEN  = 32;
  localparam int CNT_W = 8;

  logic             HCLK = 1'b0;
  logic             HRESETn;
  logic             start;
  logic [PLEN-1:0]  base;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  seed;
  logic             busy, done, bus_err;
  logic [15:0]      err_cnt;
  logic [PLEN-1:0]  first_err_addr;
  logic             HSEL, HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [PLEN-1:0]  HADDR;
  logic [XLEN-1:0]  HWDATA, HRDATA;
  logic [2:0]       HSIZE, HBURST;
  logic [3:0]       HPROT;
  logic [1:0]       HTRANS;

  always #5 HCLK = ~HCLK;

  peripheral_ahb_memtest_master #(.PLEN(PLEN), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .HRESETn(HRESETn), .HCLK(HCLK), .start(start), .base(base), .count(count), .seed(seed),
    .busy(busy), .done(done), .bus_err(bus_err), .err_cnt(err_cnt), .first_err_addr(first_err_addr),
    .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  int checks = 0;
  int failures = 0;

  // Slave RAM model with configurable wait states, read corruption and write-error injection.
  logic [XLEN-1:0] mem [0:63];
  logic            corrupt [0:63];
  int              wait_cfg = 0;
  int              err_beat = -1;
  logic            s_pend, s_write;
  logic [PLEN-1:0] s_addr;
  int              s_wait, s_err, s_wbeat;

  assign HREADY = !s_pend ? 1'b1 : (s_err == 1) ? 1'b0 : (s_err == 2) ? 1'b1 : (s_wait == 0);
  assign HRESP  = s_pend && (s_err != 0);
  assign HRDATA = (s_pend && !s_write) ? (mem[s_addr[7:2]] ^ {31'b0, corrupt[s_addr[7:2]]}) : '0;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s_pend <= 1'b0; s_write <= 1'b0; s_addr <= '0; s_wait <= 0; s_err <= 0; s_wbeat <= 0;
    end else if (HREADY) begin
      if (s_pend && s_write && s_err == 0) mem[s_addr[7:2]] <= HWDATA;
      if (HSEL && HTRANS[1]) begin
        s_pend  <= 1'b1;
        s_addr  <= HADDR;
        s_write <= HWRITE;
        s_wait  <= wait_cfg;
        s_err   <= (HWRITE && s_wbeat == err_beat) ? 1 : 0;
        if (HWRITE) s_wbeat <= s_wbeat + 1;
      end else begin
        s_pend <= 1'b0;
        s_err  <= 0;
      end
      if (start) s_wbeat <= 0;
    end else begin
      if (s_err == 1) s_err <= 2;
      else s_wait <= s_wait - 1;
    end
  end

  // Bus monitor: completed address phases, completed write data, and hold violations during waits.
  logic [PLEN-1:0] alog [$];
  logic            wrlog [$];
  logic [XLEN-1:0] wlog [$];
  int              stab_err = 0;
  logic            p_hold = 1'b0, p_wd_hold = 1'b0;
  logic [PLEN-1:0] p_addr;
  logic [1:0]      p_trans;
  logic [XLEN-1:0] p_wd;

  always @(posedge HCLK) begin
    if (HRESETn) begin
      if (HREADY && HSEL && HTRANS[1]) begin
        alog.push_back(HADDR);
        wrlog.push_back(HWRITE);
      end
      if (HREADY && s_pend && s_write && s_err == 0) wlog.push_back(HWDATA);
      if (p_hold && (HADDR !== p_addr || HTRANS !== p_trans)) stab_err++;
      if (p_wd_hold && HWDATA !== p_wd) stab_err++;
      p_hold    <= HSEL && HTRANS[1] && !HREADY && !HRESP;
      p_addr    <= HADDR;
      p_trans   <= HTRANS;
      p_wd_hold <= s_pend && s_write && !HREADY && !HRESP;
      p_wd      <= HWDATA;
    end else begin
      p_hold    <= 1'b0;
      p_wd_hold <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference results: persist across runs because results hold until the next accepted start.
  int              exp_err = 0;
  logic [PLEN-1:0] exp_first = '0;
  logic            exp_berr = 1'b0;
  logic [PLEN-1:0] exp_addr [$];
  logic [XLEN-1:0] exp_pat [$];

  function automatic logic [XLEN-1:0] ref_pattern(input logic [XLEN-1:0] sd, input int i, input logic [PLEN-1:0] a);
`ifdef PERIPHERAL_MEMTEST_ADDR_PATTERN_EN
    return sd ^ {24'b0, a};
`else
    return sd + XLEN'(i);
`endif
  endfunction

  task automatic build_model(input logic [PLEN-1:0] b, input int n, input logic [XLEN-1:0] sd, input int eb);
    logic [XLEN-1:0] mm [int];
    logic [XLEN-1:0] rd;
    exp_addr.delete();
    exp_pat.delete();
    if (n == 0) return;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(8'((int'(b) & ~3) + 4 * i));
      exp_pat.push_back(ref_pattern(sd, i, exp_addr[i]));
    end
    exp_err = 0; exp_first = '0; exp_berr = (eb >= 0);
    if (eb >= 0) return;
    for (int i = 0; i < n; i++) mm[int'(exp_addr[i]) / 4] = exp_pat[i];
    for (int i = 0; i < n; i++) begin
      rd = mm[int'(exp_addr[i]) / 4] ^ {31'b0, corrupt[int'(exp_addr[i]) / 4]};
      if (rd != exp_pat[i]) begin
        if (exp_err == 0) exp_first = exp_addr[i];
        if (exp_err < 16'hFFFF) exp_err++;
      end
    end
  endtask

  task automatic run_test(input string nm, input logic [PLEN-1:0] b, input int n, input logic [XLEN-1:0] sd,
                          input int w, input int eb, input bit inj);
    int cyc, exp_cyc, a0, w0, bad, reads;
    wait_cfg = w; err_beat = eb;
    build_model(b, n, sd, eb);
    exp_cyc = (n == 0) ? 1 : (eb >= 0) ? eb + 3 : 2 * n + 3 + 2 * n * w;
    a0 = alog.size(); w0 = wlog.size();
    @(negedge HCLK);
    base = b; count = CNT_W'(n); seed = sd; start = 1'b1;
    @(posedge HCLK); #1;
    start = 1'b0; cyc = 1;
    if (n > 0) begin
      check({nm, ".busy1"}, busy, 1);
      check({nm, ".nonseq1"}, {HSEL, HTRANS}, 3'b110);
    end
    while (!done && cyc < 1000) begin
      @(posedge HCLK); #1;
      cyc++;
      if (inj) begin
        start = (cyc == 3);
        count = (cyc == 3) ? '0 : CNT_W'(n);
      end
    end
    start = 1'b0;
    check({nm, ".done_cycle"}, cyc, exp_cyc);
    check({nm, ".busy_at_done"}, busy, 0);
    check({nm, ".err_cnt"}, err_cnt, exp_err);
    check({nm, ".first_err_addr"}, first_err_addr, exp_first);
    check({nm, ".bus_err"}, bus_err, exp_berr);
    if (eb >= 0) begin
      reads = 0;
      for (int k = a0; k < alog.size(); k++) if (!wrlog[k]) reads++;
      check({nm, ".htrans_idle"}, HTRANS, 2'b00);
      check({nm, ".no_reads"}, reads, 0);
    end else begin
      bad = 0;
      if (alog.size() - a0 != 2 * n || wlog.size() - w0 != n) bad = 1000;
      else begin
        for (int k = 0; k < 2 * n; k++)
          if (alog[a0 + k] !== exp_addr[k % n] || wrlog[a0 + k] !== (k < n)) bad++;
        for (int k = 0; k < n; k++) if (wlog[w0 + k] !== exp_pat[k]) bad++;
      end
      check({nm, ".bus_trace"}, bad, 0);
    end
    @(posedge HCLK); #1;
    check({nm, ".done_pulse"}, done, 0);
  endtask

  task automatic clear_corrupt();
    for (int k = 0; k < 64; k++) corrupt[k] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, ".busy"}, busy, 0);
    check({nm, ".done"}, done, 0);
    check({nm, ".bus_err"}, bus_err, 0);
    check({nm, ".err_cnt"}, err_cnt, 0);
    check({nm, ".first"}, first_err_addr, 0);
    check({nm, ".bus"}, {HSEL, HADDR, HWDATA, HWRITE, HTRANS}, 0);
    check({nm, ".consts"}, {HSIZE, HBURST, HPROT, HMASTLOCK}, {3'b010, 3'b001, 4'b0011, 1'b0});
  endtask

  initial begin
    int n;
    HRESETn = 1'b0; start = 1'b0; base = '0; count = '0; seed = '0;
    clear_corrupt();
    repeat (3) @(posedge HCLK);
    #1;
    check_reset_outputs("reset");
    @(negedge HCLK) HRESETn = 1'b1;

    run_test("clean", 8'h10, 4, 32'hA5A5_0000, 0, -1, 0);
    run_test("count0", 8'h40, 0, 32'h1234_5678, 0, -1, 0);
    run_test("waits", 8'h20, 3, 32'h0BAD_F00D, 2, -1, 0);
    check("hold_during_wait", stab_err, 0);

    corrupt[8'h18 / 4] = 1'b1;
    run_test("mism1", 8'h10, 4, 32'hA5A5_0000, 0, -1, 0);
    corrupt[8'h14 / 4] = 1'b1;
    corrupt[8'h1C / 4] = 1'b1;
    run_test("mism3", 8'h10, 4, 32'hA5A5_0000, 0, -1, 0);
    clear_corrupt();

    run_test("wrap", 8'hF8, 4, 32'hCAFE_0001, 0, -1, 0);
    run_test("buserr", 8'h30, 4, 32'h5555_AAAA, 0, 1, 0);
    run_test("start_busy", 8'h13, 5, 32'hFFFF_FFFE, 0, -1, 1);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 64; k++) corrupt[k] = ($urandom_range(0, 7) == 0);
      n = $urandom_range(1, 20);
      run_test($sformatf("rand%0d", r), 8'($urandom), n, $urandom, $urandom_range(0, 2), -1, 0);
    end
    clear_corrupt();
    check("hold_final", stab_err, 0);

    // Reset in the middle of the read pass.
    corrupt[8'h20 / 4] = 1'b1;
    wait_cfg = 0; err_beat = -1;
    @(negedge HCLK);
    base = 8'h20; count = 8'd8; seed = 32'h0F0F_0F0F; start = 1'b1;
    @(posedge HCLK); #1;
    start = 1'b0;
    n = 0;
    while (!(HSEL && !HWRITE) && n < 100) begin
      @(posedge HCLK); #1;
      n++;
    end
    check("reset_mid.reached_rd", HSEL && !HWRITE, 1);
    repeat (3) @(posedge HCLK);
    #2 HRESETn = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    @(negedge HCLK) HRESETn = 1'b1;
    clear_corrupt();
    exp_err = 0; exp_first = '0; exp_berr = 1'b0;
    run_test("after_reset", 8'h00, 2, 32'h0000_0001, 1, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
